// File: rtl/alu_pkg.sv
// Shared ALU definitions: AluOP encodings, the mul/div FSM state encoding
// and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_MUL  = 4'd3,
        ALU_DIV  = 4'd4,
        ALU_ADD  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_SLT  = 4'd11,
        ALU_SLTU = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract/shift for
// restoring division. {i_hi, i_lo} is the product or {remainder, quotient}.
module mul_div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
        w_shifted = {i_hi, i_lo[WIDTH-1]};
        w_fits    = (w_shifted >= {1'b0, i_operand});
        // When the trial subtract succeeds the difference is below the divisor,
        // so the low WIDTH bits hold it exactly.
        w_diff    = w_shifted[WIDTH-1:0] - i_operand;
        o_hi      = '0;
        o_lo      = '0;
        if (i_is_div) begin
            if (w_fits) begin
                o_hi = w_diff;
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shifted[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned MUL/DIV engine beside the ALU: fixed WIDTH-cycle run,
// one-cycle Done pulse, results held until the next completed operation.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       AluOP,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_2,
    output logic             DivByZero,
    output md_state_t        o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_t        r_state;
    md_state_t        w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_operand;
    logic             r_is_div;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    // Handshake: Start is a request taken only while IDLE with a MUL/DIV op;
    // Busy and Done both mean "not ready", and a refused Start is dropped.
    assign w_accept = (r_state == ST_IDLE) && Start &&
                      ((AluOP == ALU_MUL) || (AluOP == ALU_DIV));
    assign w_last      = (r_count == LAST);
    assign Busy        = (r_state == ST_RUN);
    assign Done        = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div  (r_is_div),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_operand (r_operand),
        .o_hi      (w_step_hi),
        .o_lo      (w_step_lo)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            Result    <= '0;
            Result_2  <= '0;
            DivByZero <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_is_div  <= (AluOP == ALU_DIV);
            r_hi      <= '0;
            // MUL shifts the multiplier out of r_lo; DIV shifts the dividend.
            r_lo      <= (AluOP == ALU_DIV) ? X : Y;
            r_operand <= (AluOP == ALU_DIV) ? Y : X;
        end else if (r_state == ST_RUN) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
            if (w_last) begin
                r_count   <= '0;
                Result    <= w_step_lo;
                Result_2  <= w_step_hi;
                DivByZero <= r_is_div && (r_operand == '0);
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for the multi-cycle corners.
module tb_mul_div_unit;
    import alu_pkg::*;

    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int TIMEOUT = 200;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [3:0]   AluOP;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic [W-1:0] Result_2;
    logic         DivByZero;
    md_state_t    dbg_state;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .AluOP       (AluOP),
        .X           (X),
        .Y           (Y),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .Result_2    (Result_2),
        .DivByZero   (DivByZero),
        .o_dbg_state (dbg_state)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic [W-1:0] res2;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r1, output logic [W-1:0] r2, output logic dz);
        logic [2*W-1:0] p;
        if (op == ALU_MUL) begin
            p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            r1 = p[W-1:0];
            r2 = p[2*W-1:W];
            dz = 1'b0;
        end else if (y == '0) begin
            r1 = '1;
            r2 = x;
            dz = 1'b1;
        end else begin
            r1 = x / y;
            r2 = x % y;
            dz = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issues one op and waits for Done; lat counts edges from the accept edge.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
        Start = 1'b1;
        AluOP = op;
        X     = x;
        Y     = y;
        tick();
        Start = 1'b0;
        X     = $urandom;
        Y     = $urandom;
        check("busy_after_accept", 64'(Busy), 64'(1));
        lat = 1;
        while (!Done && lat < TIMEOUT) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] op,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] er1, input logic [W-1:0] er2, input logic edz);
        int lat;
        run_op(op, x, y, lat);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_result"}, 64'(Result), 64'(er1));
        check({tag, "_result2"}, 64'(Result_2), 64'(er2));
        check({tag, "_divbyzero"}, 64'(DivByZero), 64'(edz));
        check({tag, "_busy_at_done"}, 64'(Busy), 64'(0));
        tick();
        check({tag, "_done_one_cycle"}, 64'(Done), 64'(0));
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        int done_cnt;
        logic [3:0]   op;
        logic [W-1:0] x, y, r1, r2;
        logic         dz;

        Reset = 1'b1;
        Start = 1'b0;
        AluOP = 4'd0;
        X     = '0;
        Y     = '0;
        repeat (2) tick();
        check("reset_busy", 64'(Busy), 64'(0));
        check("reset_done", 64'(Done), 64'(0));
        check("reset_result", 64'(Result), 64'(0));
        check("reset_result2", 64'(Result_2), 64'(0));
        check("reset_dz", 64'(DivByZero), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        Reset = 1'b0;
        tick();

        vecs[0] = '{ALU_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0};
        vecs[1] = '{ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[2] = '{ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[3] = '{ALU_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
        vecs[4] = '{ALU_DIV, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
        vecs[5] = '{ALU_MUL, 32'h80000000, 32'd2, 32'd0, 32'd1, 1'b0};
        for (int i = 0; i < 6; i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y,
                     vecs[i].res, vecs[i].res2, vecs[i].dz);

        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_DIV;
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 255));
                default: y = $urandom;
            endcase
            model(op, x, y, r1, r2, dz);
            check_op($sformatf("rand%0d", i), op, x, y, r1, r2, dz);
        end

        // Non-MUL/DIV op must not start the engine.
        Start = 1'b1;
        AluOP = ALU_ADD;
        X     = 32'd1;
        Y     = 32'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ignored_op_busy", 64'(Busy), 64'(0));
        end
        Start = 1'b0;

        // Start held through RUN and DONE: first result stands, one Done,
        // DONE refuses the request and the cycle after it accepts.
        Start = 1'b1;
        AluOP = ALU_MUL;
        X     = 32'd7;
        Y     = 32'd6;
        tick();
        X = 32'd9;
        Y = 32'd9;
        lat = 1;
        while (!Done && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        check("held_start_latency", 64'(lat), 64'(LAT));
        check("held_start_result", 64'(Result), 64'(42));
        tick();
        check("no_accept_in_done_busy", 64'(Busy), 64'(0));
        check("no_accept_in_done_done", 64'(Done), 64'(0));
        tick();
        check("accept_after_done", 64'(Busy), 64'(1));
        Start = 1'b0;
        check("result_held_in_run", 64'(Result), 64'(42));
        done_cnt = 0;
        lat = 2;
        while (!Done && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        check("second_op_result", 64'(Result), 64'(81));
        repeat (3) tick();
        check("result_held_in_idle", 64'(Result), 64'(81));

        // Reset during RUN aborts without a Done.
        Start = 1'b1;
        AluOP = ALU_MUL;
        X     = 32'd12345;
        Y     = 32'd678;
        tick();
        Start = 1'b0;
        repeat (10) tick();
        Reset = 1'b1;
        #1;
        check("abort_busy", 64'(Busy), 64'(0));
        check("abort_done", 64'(Done), 64'(0));
        check("abort_result", 64'(Result), 64'(0));
        check("abort_result2", 64'(Result_2), 64'(0));
        check("abort_dz", 64'(DivByZero), 64'(0));
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'(0));
        check_op("post_reset_mul", ALU_MUL, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
